// File: rtl/char_ram_arbiter.sv
// Character-RAM arbiter: one scanout read port with absolute priority and two
// round-robin writers sharing a registered single-port RAM command bus.
// Fetches run through a fixed three-cycle pipeline; writers that wait too long
// raise a sticky starvation flag.

// Per-writer saturating wait counter and sticky starvation flag.
module char_ram_wait_ctr #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic clk_25mhz,
  input  logic rst,
  input  logic req,
  input  logic acc,
  output logic starved
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt;

  // Count cycles spent requesting without acceptance; saturate at the limit.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!req || acc)
      cnt <= '0;
    else if (cnt != CNT_MAX)
      cnt <= cnt + 1'b1;
  end

  // Flag goes up the cycle after the counter hits the limit and stays up.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst)
      starved <= 1'b0;
    else if (cnt == CNT_MAX)
      starved <= 1'b1;
  end
endmodule

module char_ram_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk_25mhz,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [7:0]        fetch_data,
  output logic              fetch_valid,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [7:0]        wr_data0,
  input  logic [7:0]        wr_data1,
  output logic [1:0]        wr_gnt,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [1:0]        wr_starved
);
  localparam int NUM_WR = 2;
  // vld_pipe[0]: read command on the RAM bus; vld_pipe[1]: ram_rdata valid.
  localparam int STAGES = 1;
  localparam int CNT_W  = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } ram_cmd_t;

  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
  logic [NUM_WR-1:0][7:0]        wr_data;
  logic [NUM_WR-1:0]             wr_acc;
  logic                          last_srv;
  ram_cmd_t                      cmd_q, cmd_d;
  logic [STAGES:0]               vld_pipe;

  assign wr_addr = {wr_addr1, wr_addr0};
  assign wr_data = {wr_data1, wr_data0};
  assign wr_acc  = wr_req & wr_gnt;

  // Grant: fetch wins outright; otherwise a lone requester wins, and on a tie
  // the writer not served last goes next.
  always_comb begin
    wr_gnt = 2'b00;
    if (!rst && !fetch_req) begin
      case (wr_req)
        2'b01:   wr_gnt = 2'b01;
        2'b10:   wr_gnt = 2'b10;
        2'b11:   wr_gnt = last_srv ? 2'b01 : 2'b10;
        default: wr_gnt = 2'b00;
      endcase
    end
  end

  // Last-served pointer moves only on an accepted write; reset favours writer 0.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst)
      last_srv <= 1'b1;
    else if (wr_acc[0])
      last_srv <= 1'b0;
    else if (wr_acc[1])
      last_srv <= 1'b1;
  end

  // Next RAM command from this cycle's accepted transaction; idle holds addr/data.
  always_comb begin
    cmd_d    = cmd_q;
    cmd_d.en = 1'b0;
    cmd_d.we = 1'b0;
    if (fetch_req) begin
      cmd_d.en   = 1'b1;
      cmd_d.addr = fetch_addr;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_acc[i]) begin
          cmd_d.en    = 1'b1;
          cmd_d.we    = 1'b1;
          cmd_d.addr  = wr_addr[i];
          cmd_d.wdata = wr_data[i];
        end
      end
    end
  end

  // Registered RAM command bus; acceptance order is RAM execution order.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst)
      cmd_q <= '0;
    else
      cmd_q <= cmd_d;
  end

  assign ram_en    = cmd_q.en;
  assign ram_we    = cmd_q.we;
  assign ram_addr  = cmd_q.addr;
  assign ram_wdata = cmd_q.wdata;

  // In-flight fetch tags; reset drops anything outstanding.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst)
      vld_pipe <= '0;
    else
      vld_pipe <= {vld_pipe[STAGES-1:0], fetch_req};
  end

  // Capture read data when the tag reaches the end; data holds otherwise.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      fetch_valid <= 1'b0;
      fetch_data  <= 8'h00;
    end else begin
      fetch_valid <= vld_pipe[STAGES];
      if (vld_pipe[STAGES])
        fetch_data <= ram_rdata;
    end
  end

  for (genvar i = 0; i < NUM_WR; i++) begin : g_wait
    char_ram_wait_ctr #(
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
    ) u_wait (
      .clk_25mhz (clk_25mhz),
      .rst       (rst),
      .req       (wr_req[i]),
      .acc       (wr_acc[i]),
      .starved   (wr_starved[i])
    );
  end
endmodule

// File: tb/tb_char_ram_arbiter.sv
// Bench for char_ram_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (golden memory, fetch due-cycle queue,
// round-robin rule, consecutive-wait run lengths).
module tb_char_ram_arbiter;
  localparam int AW = 11;
  localparam int MW = 15;

  logic          clk_25mhz = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [7:0]    fetch_data;
  logic          fetch_valid;
  logic [1:0]    wr_req = 2'b00;
  logic [AW-1:0] wr_addr0 = '0, wr_addr1 = '0;
  logic [7:0]    wr_data0 = '0, wr_data1 = '0;
  logic [1:0]    wr_gnt;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;
  logic [1:0]    wr_starved;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_25mhz = ~clk_25mhz;

  char_ram_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk_25mhz   (clk_25mhz),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .fetch_valid (fetch_valid),
    .wr_req      (wr_req),
    .wr_addr0    (wr_addr0),
    .wr_addr1    (wr_addr1),
    .wr_data0    (wr_data0),
    .wr_data1    (wr_data1),
    .wr_gnt      (wr_gnt),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .wr_starved  (wr_starved)
  );

  // Preset RAM contents: swapped nibbles of the low address byte (RAM[5]=0x50).
  function automatic logic [7:0] init_val(int a);
    logic [AW-1:0] x;
    x = a[AW-1:0];
    return {x[3:0], x[7:4]};
  endfunction

  // Environment: synchronous single-port RAM, reloaded with presets during reset.
  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk_25mhz) begin
    if (rst) begin
      for (int a = 0; a < (1 << AW); a++) ram[a] <= init_val(a);
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  // ---------------- reference model ----------------
  typedef struct { int due; logic [7:0] data; } pend_t;
  pend_t         pq[$];
  logic [7:0]    m_mem [0:(1<<AW)-1];
  int            m_last;
  int            run [2];
  logic [1:0]    m_starved, m_acc;
  logic          exp_en, exp_we, exp_fv;
  logic [AW-1:0] exp_addr;
  logic [7:0]    exp_wdata, exp_fd;
  int            cyc = 0;

  task automatic model_reset();
    m_last = 1;
    run[0] = 0; run[1] = 0;
    m_starved = 2'b00; m_acc = 2'b00;
    pq.delete();
    exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
    exp_fv = 0; exp_fd = '0;
    for (int a = 0; a < (1 << AW); a++) m_mem[a] = init_val(a);
  endtask

  // Fetch first; otherwise the requesting writer that was not served last.
  function automatic logic [1:0] model_gnt();
    if (rst || fetch_req) return 2'b00;
    if (wr_req == 2'b11) return (m_last == 0) ? 2'b10 : 2'b01;
    return wr_req;
  endfunction

  // Advance one clock edge and update the model with what was accepted.
  task automatic tick();
    logic [1:0] acc;
    pend_t p;
    int w;
    acc = wr_req & model_gnt();
    @(posedge clk_25mhz);
    if (rst) model_reset();
    else begin
      m_acc = acc;
      for (int i = 0; i < 2; i++) if (run[i] >= MW) m_starved[i] = 1'b1;
      for (int i = 0; i < 2; i++) run[i] = (wr_req[i] && !acc[i]) ? run[i] + 1 : 0;
      if (fetch_req) begin
        exp_en = 1; exp_we = 0; exp_addr = fetch_addr;
        p.due = cyc + 3; p.data = m_mem[fetch_addr];
        pq.push_back(p);
      end else if (acc != 2'b00) begin
        w = acc[1] ? 1 : 0;
        exp_en = 1; exp_we = 1;
        exp_addr  = w ? wr_addr1 : wr_addr0;
        exp_wdata = w ? wr_data1 : wr_data0;
        m_mem[exp_addr] = exp_wdata;
        m_last = w;
      end else begin
        exp_en = 0; exp_we = 0;
      end
    end
    cyc++;
    exp_fv = 0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      exp_fv = 1; exp_fd = pq[0].data;
      void'(pq.pop_front());
    end
    #1;
  endtask

  task automatic idle(int n);
    fetch_req = 0; wr_req = 2'b00;
    repeat (n) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; wr_req = 2'b11; fetch_req = 0;
    model_reset();
    #2;
    n_chk++;
    if (wr_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", wr_gnt); end
    n_chk++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, fetch_valid, fetch_data, wr_starved} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%b we=%b addr=%h wd=%h fv=%b fd=%h st=%b want all zero",
               ram_en, ram_we, ram_addr, ram_wdata, fetch_valid, fetch_data, wr_starved);
    end
    tick(); tick();
    rst = 0; wr_req = 2'b00;
    tick();
  endtask

  task automatic test_single_fetch();
    fetch_req = 1; fetch_addr = 11'h005;
    #1;
    n_chk++;
    if (wr_gnt !== 2'b00) begin n_fail++; $display("FAIL sf_gnt: got %b want 00", wr_gnt); end
    tick();                                    // cycle 1
    fetch_req = 0;
    n_chk++;
    if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 11'h005}) begin
      n_fail++; $display("FAIL sf_cmd: en=%b we=%b addr=%h want 1 0 005", ram_en, ram_we, ram_addr);
    end
    n_chk++;
    if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL sf_fv_c1: got %b want 0", fetch_valid); end
    tick();                                    // cycle 2
    n_chk++;
    if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL sf_fv_c2: got %b want 0", fetch_valid); end
    tick();                                    // cycle 3
    n_chk++;
    if ({fetch_valid, fetch_data} !== {1'b1, 8'h50}) begin
      n_fail++; $display("FAIL sf_data: fv=%b fd=%h want 1 50", fetch_valid, fetch_data);
    end
    tick();                                    // cycle 4: valid drops, data held
    n_chk++;
    if ({fetch_valid, fetch_data} !== {1'b0, 8'h50}) begin
      n_fail++; $display("FAIL sf_hold: fv=%b fd=%h want 0 50", fetch_valid, fetch_data);
    end
  endtask

  task automatic test_contention();
    fetch_req = 1; fetch_addr = 11'h007;
    wr_req = 2'b11;
    wr_addr0 = 11'h020; wr_data0 = 8'hAA;
    wr_addr1 = 11'h021; wr_data1 = 8'hBB;
    #1;
    n_chk++;
    if (wr_gnt !== 2'b00) begin n_fail++; $display("FAIL ct_gnt_c0: got %b want 00", wr_gnt); end
    tick();                                    // cycle 1
    fetch_req = 0;
    #1;
    n_chk++;
    if (wr_gnt !== 2'b01) begin n_fail++; $display("FAIL ct_gnt_c1: got %b want 01", wr_gnt); end
    tick();                                    // cycle 2
    wr_req = 2'b10;
    n_chk++;
    if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 11'h020, 8'hAA}) begin
      n_fail++; $display("FAIL ct_wr_c2: we=%b addr=%h wd=%h want 1 020 aa", ram_we, ram_addr, ram_wdata);
    end
    #1;
    n_chk++;
    if (wr_gnt !== 2'b10) begin n_fail++; $display("FAIL ct_gnt_c2: got %b want 10", wr_gnt); end
    tick();                                    // cycle 3
    wr_req = 2'b00;
    n_chk++;
    if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 11'h021, 8'hBB}) begin
      n_fail++; $display("FAIL ct_wr_c3: we=%b addr=%h wd=%h want 1 021 bb", ram_we, ram_addr, ram_wdata);
    end
    n_chk++;
    if ({fetch_valid, fetch_data} !== {1'b1, 8'h70}) begin
      n_fail++; $display("FAIL ct_fetch: fv=%b fd=%h want 1 70", fetch_valid, fetch_data);
    end
    tick();                                    // cycle 4
    n_chk++;
    if ({ram_en, ram_we} !== 2'b00) begin n_fail++; $display("FAIL ct_idle: en=%b we=%b want 0 0", ram_en, ram_we); end
  endtask

  task automatic test_round_robin();
    int c0, c1, bad;
    c0 = 0; c1 = 0; bad = 0;
    fetch_req = 0; wr_req = 2'b11;
    for (int k = 0; k < 8; k++) begin
      wr_addr0 = 11'h100 + AW'($urandom_range(0, 127)); wr_data0 = 8'($urandom);
      wr_addr1 = 11'h180 + AW'($urandom_range(0, 127)); wr_data1 = 8'($urandom);
      #1;
      if (wr_gnt !== ((k % 2 == 0) ? 2'b01 : 2'b10)) bad++;
      if (wr_gnt === 2'b01) c0++;
      if (wr_gnt === 2'b10) c1++;
      tick();
    end
    wr_req = 2'b00;
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL rr_order: %0d cycles off the 01/10 alternation, want 0", bad); end
    n_chk++;
    if (c0 != 4 || c1 != 4) begin n_fail++; $display("FAIL rr_count: w0=%0d w1=%0d want 4 4", c0, c1); end
    tick();
  endtask

  task automatic test_write_then_read();
    fetch_req = 0; wr_req = 2'b01; wr_addr0 = 11'h010; wr_data0 = 8'h41;
    #1;
    n_chk++;
    if (wr_gnt !== 2'b01) begin n_fail++; $display("FAIL wtr_gnt: got %b want 01", wr_gnt); end
    tick();                                    // cycle 1
    wr_req = 2'b00; fetch_req = 1; fetch_addr = 11'h010;
    tick();                                    // cycle 2
    fetch_req = 0;
    tick();                                    // cycle 3
    n_chk++;
    if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL wtr_early: fv=%b want 0", fetch_valid); end
    tick();                                    // cycle 4
    n_chk++;
    if ({fetch_valid, fetch_data} !== {1'b1, 8'h41}) begin
      n_fail++; $display("FAIL wtr_data: fv=%b fd=%h want 1 41", fetch_valid, fetch_data);
    end
  endtask

  task automatic test_starvation();
    int bad;
    bad = 0;
    wr_req = 2'b01; wr_addr0 = 11'h300; wr_data0 = 8'h77;
    for (int k = 0; k < 20; k++) begin
      fetch_req = 1; fetch_addr = AW'($urandom_range(0, 63));
      #1;
      if (wr_starved !== ((k >= 16) ? 2'b01 : 2'b00)) begin
        bad++;
        $display("FAIL starve_c%0d: got %b want %b", k, wr_starved, (k >= 16) ? 2'b01 : 2'b00);
      end
      tick();
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL starve_onset: %0d wrong cycles, want 0", bad); end
    fetch_req = 0;
    #1;
    n_chk++;
    if (wr_gnt !== 2'b01) begin n_fail++; $display("FAIL starve_gnt: got %b want 01", wr_gnt); end
    tick();
    wr_req = 2'b00;
    tick();
    n_chk++;
    if (wr_starved !== 2'b01) begin n_fail++; $display("FAIL starve_sticky: got %b want 01", wr_starved); end
    idle(4);
  endtask

  task automatic test_reset_midflight();
    int bad;
    bad = 0;
    fetch_req = 1; fetch_addr = 11'h0AB;
    tick();                                    // cycle 1
    fetch_req = 0; wr_req = 2'b11; rst = 1;
    model_reset();
    #1;
    n_chk++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, fetch_valid, fetch_data, wr_starved, wr_gnt} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: en=%b we=%b addr=%h wd=%h fv=%b fd=%h st=%b gnt=%b want all zero",
               ram_en, ram_we, ram_addr, ram_wdata, fetch_valid, fetch_data, wr_starved, wr_gnt);
    end
    tick();                                    // cycle 2
    rst = 0; wr_req = 2'b00;
    for (int k = 2; k <= 5; k++) begin
      if (fetch_valid !== 1'b0) bad++;
      tick();
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL rstmid_fv: %0d stray valid cycles, want 0", bad); end
  endtask

  task automatic test_random();
    int bad_cmd, bad_fetch, bad_st, bad_gnt;
    bad_cmd = 0; bad_fetch = 0; bad_st = 0; bad_gnt = 0;
    m_acc = 2'b00;
    for (int k = 0; k < 400; k++) begin
      // Registered outputs for this cycle.
      if ({ram_en, ram_we, ram_addr, ram_wdata} !== {exp_en, exp_we, exp_addr, exp_wdata}) begin
        bad_cmd++;
        if (bad_cmd < 4) $display("FAIL rnd_cmd@%0d: en=%b we=%b addr=%h wd=%h want %b %b %h %h",
                                  k, ram_en, ram_we, ram_addr, ram_wdata, exp_en, exp_we, exp_addr, exp_wdata);
      end
      if ({fetch_valid, fetch_data} !== {exp_fv, exp_fd}) begin
        bad_fetch++;
        if (bad_fetch < 4) $display("FAIL rnd_fetch@%0d: fv=%b fd=%h want %b %h", k, fetch_valid, fetch_data, exp_fv, exp_fd);
      end
      if (wr_starved !== m_starved) begin
        bad_st++;
        if (bad_st < 4) $display("FAIL rnd_starved@%0d: got %b want %b", k, wr_starved, m_starved);
      end
      // New stimulus: writers hold until accepted; a fetch burst forces waits.
      if (!wr_req[0] || m_acc[0]) begin
        wr_req[0] = ($urandom_range(0, 2) == 0);
        wr_addr0 = AW'($urandom_range(0, 31)); wr_data0 = 8'($urandom);
      end
      if (!wr_req[1] || m_acc[1]) begin
        wr_req[1] = ($urandom_range(0, 2) == 0);
        wr_addr1 = AW'($urandom_range(0, 31)); wr_data1 = 8'($urandom);
      end
      m_acc = 2'b00;
      fetch_req = (k >= 100 && k < 125) ? 1'b1 : ($urandom_range(0, 99) < 35);
      fetch_addr = AW'($urandom_range(0, 31));
      #1;
      if (wr_gnt !== model_gnt()) begin
        bad_gnt++;
        if (bad_gnt < 4) $display("FAIL rnd_gnt@%0d: got %b want %b", k, wr_gnt, model_gnt());
      end
      tick();
    end
    n_chk++; if (bad_cmd != 0)   begin n_fail++; $display("FAIL rnd_cmd_total: %0d bad cycles, want 0", bad_cmd); end
    n_chk++; if (bad_fetch != 0) begin n_fail++; $display("FAIL rnd_fetch_total: %0d bad cycles, want 0", bad_fetch); end
    n_chk++; if (bad_st != 0)    begin n_fail++; $display("FAIL rnd_starved_total: %0d bad cycles, want 0", bad_st); end
    n_chk++; if (bad_gnt != 0)   begin n_fail++; $display("FAIL rnd_gnt_total: %0d bad cycles, want 0", bad_gnt); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_round_robin();
    test_write_then_read();
    idle(3);
    test_starvation();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
